joy_port: RTL and testbench
===========================

Name: joy_port

Overview:
- CPU-bus responder for the NES controller registers $4016/$4017.
- Also acts as the serial initiator toward two physical NES pads on GPIO: pad_latch, pad_clk, two data lines.
- Sits beside mem_ram/mem_rom on the 6502 bus:
  - the top-level address decoder raises `sel` for $4016–$4017;
  - the top-level read mux takes `q` when `sel` is high.

Parameters:
- CLK_DIV, 150: clock cycles per pad_latch/pad_clk half-period (6 µs at 25 MHz).
- SCAN_PERIOD, 416666: cycles between scan starts (60 Hz at 25 MHz). Must be greater than 20*CLK_DIV.

Ports:
- clock, in, 1: system clock (25 MHz domain of the CPU).
- reset, in, 1: asynchronous, active-high.
- address, in, 16: CPU address bus.
- sel, in, 1: decoder hit for $4016/$4017.
- we, in, 1: CPU write strobe.
- rd, in, 1: CPU read strobe.
- d, in, 8: CPU write data.
- q, out, 8: read data.
- pad_latch, out, 1: pad latch, active-high.
- pad_clk, out, 1: pad shift clock.
- pad_data1, in, 1: pad 1 serial data, active-low (0 = pressed).
- pad_data2, in, 1: pad 2 serial data, active-low.
- btn1, out, 8: debounced snapshot of pad 1, pressed = 1. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- btn2, out, 8: same for pad 2.

Behaviour:
- Interface: one clock (`clock`). Reset is asynchronous and active-high on port `reset`.
- Reset values:
  - pad_latch=0, pad_clk=0; btn1=btn2=8'h00; strobe=0; shift regs sh1=sh2=8'h00.
  - q=8'h40; scanner in IDLE with period counter 0.
- pad_data1/2 pass through 2-flop synchronizers before use.
- Scanner FSM (one shared engine drives both pads in parallel):
  - IDLE: period counter counts to SCAN_PERIOD-1. At terminal count (or at the first cycle after reset), go to LATCH.
  - LATCH: pad_latch=1 for 2*CLK_DIV cycles, then go to SAMPLE with bit index 0.
  - SAMPLE: one cycle. Capture ~sync1 into acc1[i] and ~sync2 into acc2[i]. If i==7, go to DONE; else go to CLKH.
  - CLKH: pad_clk=1 for CLK_DIV cycles, then go to CLKL.
  - CLKL: pad_clk=0 for CLK_DIV cycles, then i++ and go to SAMPLE.
  - DONE: one cycle. btn1<=acc1, btn2<=acc2, then go to IDLE.
  - The period counter runs in every state, so the scan period is exactly SCAN_PERIOD.
  - Scan length is 2*CLK_DIV + 7*2*CLK_DIV + 8 + 1 cycles.
- CPU write: when sel & we & address[0]==0 (i.e. $4016), strobe<=d[0]. Writes to $4017 are ignored (APU frame counter lives elsewhere).
- Strobe behaviour:
  - While strobe=1: sh1<=btn1 and sh2<=btn2 every cycle.
  - When strobe=0: the shift regs hold their contents.
- Read data, combinational:
  - q = {7'b0100000, sh1[0]} when address[0]==0.
  - q = {7'b0100000, sh2[0]} when address[0]==1.
  - q = 8'h40 when sel=0.
- Read shift:
  - Trigger: the rising edge of (sel & rd), detected with a registered copy. A multi-cycle rd shifts exactly once.
  - On a trigger with strobe=0, the addressed reg shifts right with 1 filled into bit 7.
  - After 8 reads, every further read returns bit 1 (q=8'h41).
- Simultaneous events:
  - A read while strobe=1 does not shift and returns btn[0] live.
  - A write that clears strobe in the same cycle as a read-edge: the reload happens that cycle and the shift does not.
  - A DONE update during strobe=0 does not disturb sh1/sh2.
- Reset mid-scan: the scanner aborts asynchronously, latch/clk drop to 0 immediately, and a fresh scan starts after reset deasserts. btn values reset to 0 and are not retained.

Decomposition:
- Package joy_pkg holds:
  - constants JOY1_ADDR=16'h4016 and JOY2_ADDR=16'h4017;
  - button bit indices BTN_A..BTN_RIGHT;
  - open-bus constant JOY_OPEN=8'h40;
  - scanner state enum {IDLE, LATCH, SAMPLE, CLKH, CLKL, DONE}.
- Sub-module joy_scan contains the scanner FSM, the synchronizers and btn1/btn2.
- joy_port contains the CPU register file, strobe and shift regs.

Test Plan (bench uses CLK_DIV=2, SCAN_PERIOD=100):
- Reset release, pad model drives pad1 bits = A and Start pressed (serial 0,1,1,0,1,1,1,1) → after first DONE, btn1=8'h09. Waveform shows pad_latch high for 4 cycles, 7 pad_clk pulses, next scan starts 100 cycles after the first.
- Write $4016=1 then $4016=0, then 10 reads of $4016 → q = 41,40,40,41,40,40,40,40,41,41.
- Hold rd high for 5 cycles on one $4016 access → a single shift; next read returns the bit-1 value.
- With strobe=1, 3 reads of $4016 with btn1=8'h01 → each returns 8'h41 and sh1 stays at 8'h01. A pad change to A released between scans makes the next read after DONE return 8'h40.
- Pad2 Right pressed only → btn2=8'h80. After strobe pulse, reads of $4017 return 8'h40 seven times, then 8'h41.
- Assert reset while in CLKH → pad_clk=0 and pad_latch=0 the same cycle, btn1=00, q=8'h40. A full scan completes after release.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared constants and types for the NES controller port block.
package joy_pkg;

  // CPU-visible register addresses
  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  // Button bit positions inside btn1/btn2 and the pad serial order
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Open-bus value returned in the upper bits of every read
  localparam logic [7:0] JOY_OPEN = 8'h40;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    CLKH,
    CLKL,
    DONE
  } scan_state_t;

endpackage

// File: rtl/joy_scan.sv
// Periodic serial scanner for two NES pads sharing one latch/clock pair.
module joy_scan
  import joy_pkg::*;
#(
  parameter int CLK_DIV     = 150,
  parameter int SCAN_PERIOD = 416666
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pad_data1,
  input  logic        pad_data2,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [7:0]  btn1,
  output logic [7:0]  btn2,
  output scan_state_t dbg_state
);

  localparam int DW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(SCAN_PERIOD - 1);

  scan_state_t   state;
  logic [DW-1:0] div;
  logic [2:0]    bit_idx;
  logic [7:0]    acc1;
  logic [7:0]    acc2;
  logic [PW-1:0] per_cnt;
  logic          first;
  logic          scan_go;
  logic          sync1_a, sync1_b;
  logic          sync2_a, sync2_b;

  assign dbg_state = state;
  // A scan starts on the first cycle out of reset and then every SCAN_PERIOD cycles
  assign scan_go   = first || (per_cnt == PER_LAST);

  // Two-flop synchronizers; idle line level is high (button released)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_a <= 1'b1;
      sync1_b <= 1'b1;
      sync2_a <= 1'b1;
      sync2_b <= 1'b1;
    end else begin
      sync1_a <= pad_data1;
      sync1_b <= sync1_a;
      sync2_a <= pad_data2;
      sync2_b <= sync2_a;
    end
  end

  // Free-running period counter, restarted together with each scan start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
      first   <= 1'b1;
    end else begin
      first <= 1'b0;
      if (scan_go) per_cnt <= '0;
      else         per_cnt <= per_cnt + 1'b1;
    end
  end

  // Scanner FSM: latch pulse, then 8 samples separated by 7 clock pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      bit_idx   <= '0;
      acc1      <= '0;
      acc2      <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      btn1      <= '0;
      btn2      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_go) begin
            pad_latch <= 1'b1;
            div       <= '0;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (div == LATCH_LAST) begin
            pad_latch <= 1'b0;
            bit_idx   <= '0;
            state     <= SAMPLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        SAMPLE: begin
          acc1[bit_idx] <= ~sync1_b;
          acc2[bit_idx] <= ~sync2_b;
          div           <= '0;
          if (bit_idx == 3'd7) begin
            state <= DONE;
          end else begin
            pad_clk <= 1'b1;
            state   <= CLKH;
          end
        end
        CLKH: begin
          if (div == HALF_LAST) begin
            pad_clk <= 1'b0;
            div     <= '0;
            state   <= CLKL;
          end else begin
            div <= div + 1'b1;
          end
        end
        CLKL: begin
          if (div == HALF_LAST) begin
            bit_idx <= bit_idx + 1'b1;
            state   <= SAMPLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          btn1  <= acc1;
          btn2  <= acc2;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/joy_port.sv
// $4016/$4017 controller registers: strobe, read shift registers, pad scanner.
//
// Bus semantics: the CPU presents address/d with sel for one or more cycles.
// A write acts on every cycle where sel & we is high. A read acts once, on the
// first cycle of sel & rd; q is combinational and valid whenever sel is high.
module joy_port
  import joy_pkg::*;
#(
  parameter int CLK_DIV     = 150,
  parameter int SCAN_PERIOD = 416666
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        sel,
  input  logic        we,
  input  logic        rd,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_data1,
  input  logic        pad_data2,
  output logic [7:0]  btn1,
  output logic [7:0]  btn2
);

  logic        strobe;
  logic [7:0]  sh1;
  logic [7:0]  sh2;
  logic        rd_prev;
  logic        rd_edge;
  logic        wr_4016;
  logic        rd_bit;
  scan_state_t scan_state;
  logic        unused_bits;

  // Only address[0] distinguishes the two registers; the decoder owns the rest
  assign unused_bits = ^{address[15:1], d[7:1], scan_state};
  assign wr_4016     = sel && we && !address[0];
  assign rd_edge     = sel && rd && !rd_prev;

  joy_scan #(
    .CLK_DIV     (CLK_DIV),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .pad_data1 (pad_data1),
    .pad_data2 (pad_data2),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .btn1      (btn1),
    .btn2      (btn2),
    .dbg_state (scan_state)
  );

  // Strobe register written from $4016 bit 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) strobe <= 1'b0;
    else if (wr_4016) strobe <= d[0];
  end

  // Read-edge detector so a long rd pulse shifts only once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_prev <= 1'b0;
    else       rd_prev <= sel && rd;
  end

  // Shift registers: reload while strobed, otherwise shift in 1s on each read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh1 <= '0;
      sh2 <= '0;
    end else if (strobe) begin
      sh1 <= btn1;
      sh2 <= btn2;
    end else if (rd_edge) begin
      if (address[0]) sh2 <= {1'b1, sh2[7:1]};
      else            sh1 <= {1'b1, sh1[7:1]};
    end
  end

  // Read mux: while strobed the current button A state is visible live
  always_comb begin
    rd_bit = 1'b0;
    q      = JOY_OPEN;
    if (address[0]) rd_bit = strobe ? btn2[BTN_A] : sh2[0];
    else            rd_bit = strobe ? btn1[BTN_A] : sh1[0];
    if (sel) q = {JOY_OPEN[7:1], rd_bit};
  end

endmodule

// File: tb/tb_joy_port.sv
// Directed bench for joy_port with a small NES pad model and a read scoreboard.
module tb_joy_port;
  import joy_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int SCAN_PERIOD = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        sel, we, rd;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        pad_latch, pad_clk;
  logic        pad_data1, pad_data2;
  logic [7:0]  btn1, btn2;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];

  joy_port #(
    .CLK_DIV     (CLK_DIV),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .sel       (sel),
    .we        (we),
    .rd        (rd),
    .d         (d),
    .q         (q),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data1 (pad_data1),
    .pad_data2 (pad_data2),
    .btn1      (btn1),
    .btn2      (btn2)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- pad model ----------------
  // pad*_line[i] is the serial line level for bit i (0 = pressed)
  logic [7:0] pad1_line;
  logic [7:0] pad2_line;
  int         pad_idx = 0;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch)        pad_idx = 0;
    else if (pad_idx < 8) pad_idx = pad_idx + 1;
  end

  assign pad_data1 = (pad_idx < 8) ? pad1_line[pad_idx[2:0]] : 1'b1;
  assign pad_data2 = (pad_idx < 8) ? pad2_line[pad_idx[2:0]] : 1'b1;

  // ---------------- checking ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every new CPU read access pops one expected read value
  logic rd_seen = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      rd_seen = 1'b0;
    end else begin
      if (sel && rd && !rd_seen) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL read_unexpected: got %02h expected none", q);
        end else begin
          check8(name_q.pop_front(), q, exp_q.pop_front());
        end
      end
      rd_seen = sel && rd;
    end
  end

  // ---------------- drivers ----------------
  task automatic bus(input logic [15:0] a, input logic w, input logic r,
                     input logic [7:0] dv, input int hold,
                     input logic [7:0] exp, input string name);
    if (r) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clock); #1;
    address = a; sel = 1'b1; we = w; rd = r; d = dv;
    repeat (hold) @(posedge clock);
    #1;
    sel = 1'b0; we = 1'b0; rd = 1'b0; d = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] dv);
    bus(a, 1'b1, 1'b0, dv, 1, 8'h00, "");
  endtask

  task automatic rd_exp(input logic [15:0] a, input logic [7:0] exp, input string name);
    bus(a, 1'b0, 1'b1, 8'h00, 1, exp, name);
  endtask

  task automatic wait_btn(input logic [7:0] e1, input logic [7:0] e2, input string name);
    int k;
    k = 0;
    while ((btn1 !== e1 || btn2 !== e2) && k < 400) begin
      @(negedge clock);
      k++;
    end
    check8({name, "_btn1"}, btn1, e1);
    check8({name, "_btn2"}, btn2, e2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         k;
    int         lat_cyc;
    int         clk_pulses;
    int         gap;
    logic       prev_clk;
    logic [7:0] seq1 [10];

    seq1 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

    reset = 1'b1; address = 16'h0000; sel = 1'b0; we = 1'b0; rd = 1'b0; d = 8'h00;
    pad1_line = 8'hF6;   // A and Start pressed
    pad2_line = 8'hFF;   // nothing pressed
    repeat (3) @(negedge clock);
    check8("rst_latch", {7'b0, pad_latch}, 8'h00);
    check8("rst_clk",   {7'b0, pad_clk},   8'h00);
    check8("rst_btn1",  btn1, 8'h00);
    check8("rst_btn2",  btn2, 8'h00);
    check8("rst_q",     q,    8'h40);
    check8("rst_state", 8'(dut.scan_state), 8'(IDLE));
    @(posedge clock); #1;
    reset = 1'b0;

    // First scan: latch width, clock pulse count, result, period
    k = 0;
    while (!pad_latch && k < 50) begin
      @(negedge clock);
      k++;
    end
    check8("first_latch_seen", {7'b0, pad_latch}, 8'h01);
    lat_cyc = 0; clk_pulses = 0; prev_clk = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (pad_latch) lat_cyc++;
      if (pad_clk && !prev_clk) clk_pulses++;
      prev_clk = pad_clk;
      @(negedge clock);
    end
    check_int("latch_cycles", lat_cyc, 2 * CLK_DIV);
    check_int("clk_pulses",   clk_pulses, 7);
    check8("scan1_btn1", btn1, 8'h09);
    check8("scan1_btn2", btn2, 8'h00);
    gap = 60;
    while (!pad_latch && gap < 200) begin
      @(negedge clock);
      gap++;
    end
    check_int("scan_period", gap, SCAN_PERIOD);

    // Strobe pulse then ten reads of $4016
    wr(JOY1_ADDR, 8'h01);
    wr(JOY1_ADDR, 8'h00);
    for (int i = 0; i < 10; i++) rd_exp(JOY1_ADDR, seq1[i], $sformatf("read4016_%0d", i));

    // Long rd pulse shifts exactly once
    wr(JOY1_ADDR, 8'h01);
    wr(JOY1_ADDR, 8'h00);
    bus(JOY1_ADDR, 1'b0, 1'b1, 8'h00, 5, 8'h41, "hold_read");
    rd_exp(JOY1_ADDR, 8'h40, "after_hold_b");
    rd_exp(JOY1_ADDR, 8'h40, "after_hold_sel");
    rd_exp(JOY1_ADDR, 8'h41, "after_hold_start");

    // Strobe held high: reads do not shift and show button A live
    pad1_line = 8'hFE;   // A only
    pad2_line = 8'h7F;   // Right only
    wait_btn(8'h01, 8'h80, "a_only");
    wr(JOY1_ADDR, 8'h01);
    for (int i = 0; i < 3; i++) rd_exp(JOY1_ADDR, 8'h41, $sformatf("strobe_read_%0d", i));
    @(negedge clock);
    check8("strobe_sh1", dut.sh1, 8'h01);
    pad1_line = 8'hFF;
    wait_btn(8'h00, 8'h80, "a_released");
    rd_exp(JOY1_ADDR, 8'h40, "live_read");

    // Clear strobe in the same cycle as a read edge, then walk both registers
    pad1_line = 8'hF6;
    wait_btn(8'h09, 8'h80, "both");
    bus(JOY1_ADDR, 1'b1, 1'b1, 8'h00, 1, 8'h41, "clear_with_read");
    rd_exp(JOY1_ADDR, 8'h41, "post_clear_a");
    rd_exp(JOY1_ADDR, 8'h40, "post_clear_b");
    for (int i = 0; i < 7; i++) rd_exp(JOY2_ADDR, 8'h40, $sformatf("read4017_%0d", i));
    rd_exp(JOY2_ADDR, 8'h41, "read4017_right");
    rd_exp(JOY2_ADDR, 8'h41, "read4017_fill");

    // Reset in the middle of a clock-high phase
    k = 0;
    while (dut.scan_state != CLKH && k < 200) begin
      @(negedge clock);
      k++;
    end
    check8("clkh_pad_clk", {7'b0, pad_clk}, 8'h01);
    #1 reset = 1'b1;
    #1;
    check8("midrst_clk",   {7'b0, pad_clk},   8'h00);
    check8("midrst_latch", {7'b0, pad_latch}, 8'h00);
    check8("midrst_btn1",  btn1, 8'h00);
    check8("midrst_btn2",  btn2, 8'h00);
    check8("midrst_q",     q,    8'h40);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_btn(8'h09, 8'h80, "rescan");

    repeat (3) @(negedge clock);
    check_int("scoreboard_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
